mc_control_fsm: RTL and testbench

Multi-cycle control unit for the workshop RV32I core; it is the producer side of the 4-bit ALU operation interface.
- Sequences FETCH/DECODE/EXEC/MEM/WB over a shared ALU and a single-port memory with a req/ready handshake.
- Drives alu_op, operand selects and all datapath write-enables.

---
 rtl/mc_control_fsm_pkg.sv | 68 ++++++
 rtl/mc_control_fsm_if.sv | 42 ++++
 rtl/mc_control_fsm_alu_op_decoder.sv | 40 ++++
 rtl/mc_control_fsm.sv | 193 +++++++++++++++++++
 tb/tb_mc_control_fsm.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/mc_control_fsm_pkg.sv
// ----------------------------------------------------------------------------
// riscv_ctrl_pkg
// Shared types and constants for the multi-cycle RV32I control unit:
//   alu_op_e   - 4-bit ALU operation codes driven to the datapath ALU
//   state_e    - control FSM states (TRAP only reachable with ILLEGAL_TRAP_EN)
//   OPC_*      - base opcode constants (instr[6:0])
//   PC_SEL_* / WB_SEL_* - encodings of the pc_sel and wb_sel muxes
//   opcode_legal() - true when the opcode belongs to the supported subset
// ----------------------------------------------------------------------------
package riscv_ctrl_pkg;

   typedef enum logic [3:0] {
      ALU_ADD   = 4'b0000,
      ALU_SUB   = 4'b0001,
      ALU_SLL   = 4'b0010,
      ALU_SRL   = 4'b0011,
      ALU_SRA   = 4'b0100,
      ALU_SLT   = 4'b0101,
      ALU_SLTU  = 4'b0110,
      ALU_XOR   = 4'b0111,
      ALU_OR    = 4'b1000,
      ALU_AND   = 4'b1001,
      ALU_PASSB = 4'b1010
   } alu_op_e;

   // FETCH is encoded as zero so the debug state output reads FETCH while
   // reset holds every output low.
   typedef enum logic [2:0] {
      FETCH  = 3'd0,
      DECODE = 3'd1,
      EXEC   = 3'd2,
      MEM    = 3'd3,
      WB     = 3'd4,
      TRAP   = 3'd5
   } state_e;

   localparam state_e RESET_STATE = FETCH;

   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_FENCE  = 7'b0001111;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

   localparam logic [1:0] PC_SEL_PC4       = 2'd0;
   localparam logic [1:0] PC_SEL_ALU       = 2'd1;
   localparam logic [1:0] PC_SEL_ALU_ALIGN = 2'd2;

   localparam logic [1:0] WB_SEL_ALU = 2'd0;
   localparam logic [1:0] WB_SEL_MEM = 2'd1;
   localparam logic [1:0] WB_SEL_PC4 = 2'd2;

   // SYSTEM is deliberately left out of the list: this core has no CSRs or
   // environment calls, so it is treated like any other unknown opcode.
   function automatic logic opcode_legal(input logic [6:0] opc);
      return (opc[1:0] == 2'b11) &&
             (opc inside {OPC_LOAD, OPC_FENCE, OPC_OP_IMM, OPC_AUIPC,
                          OPC_STORE, OPC_OP, OPC_LUI, OPC_BRANCH,
                          OPC_JALR, OPC_JAL});
   endfunction

endpackage

// File: rtl/mc_control_fsm_if.sv
// ----------------------------------------------------------------------------
// mc_control_fsm_if
// Bundle between the control unit and the datapath / memory.
//   master modport (control unit): takes instr, mem_ready, br_taken and drives
//     mem_req, mem_we, mem_addr_sel, ir_we, pc_we, pc_sel, alu_op, alu_a_sel,
//     alu_b_sel, reg_we, wb_sel, state_o, illegal.
//   slave modport (datapath side): the mirror image.
// ----------------------------------------------------------------------------
interface mc_control_fsm_if;
   import riscv_ctrl_pkg::*;

   logic [31:0] instr;
   logic        mem_ready;
   logic        br_taken;

   logic        mem_req;
   logic        mem_we;
   logic        mem_addr_sel;
   logic        ir_we;
   logic        pc_we;
   logic [1:0]  pc_sel;
   alu_op_e     alu_op;
   logic        alu_a_sel;
   logic        alu_b_sel;
   logic        reg_we;
   logic [1:0]  wb_sel;
   logic [2:0]  state_o;
   logic        illegal;

   modport master (
      input  instr, mem_ready, br_taken,
      output mem_req, mem_we, mem_addr_sel, ir_we, pc_we, pc_sel, alu_op,
             alu_a_sel, alu_b_sel, reg_we, wb_sel, state_o, illegal
   );

   modport slave (
      output instr, mem_ready, br_taken,
      input  mem_req, mem_we, mem_addr_sel, ir_we, pc_we, pc_sel, alu_op,
             alu_a_sel, alu_b_sel, reg_we, wb_sel, state_o, illegal
   );

endinterface

// File: rtl/mc_control_fsm_alu_op_decoder.sv
// ----------------------------------------------------------------------------
// alu_op_decoder
// Purely combinational map from (opcode, funct3, instr[30]) to the ALU op.
//   opcode  in  7  instr[6:0]
//   funct3  in  3  instr[14:12]
//   instr30 in  1  instr[30] (SUB / SRA selector)
//   alu_op  out 4  ALU operation
// ----------------------------------------------------------------------------
module alu_op_decoder
   import riscv_ctrl_pkg::*;
(
   input  logic [6:0] opcode,
   input  logic [2:0] funct3,
   input  logic       instr30,
   output alu_op_e    alu_op
);

   // Only OP and OP-IMM look at funct3. LUI passes the immediate through;
   // everything else (AUIPC, loads, stores, branches, jumps) needs an address
   // add. instr[30] selects SUB only for register-register ops because in
   // OP-IMM that bit is part of the immediate, except for the shift encoding.
   always_comb begin
      alu_op = ALU_ADD;
      if (opcode == OPC_LUI) begin
         alu_op = ALU_PASSB;
      end else if (opcode == OPC_OP || opcode == OPC_OP_IMM) begin
         case (funct3)
            3'b000: alu_op = (opcode == OPC_OP && instr30) ? ALU_SUB : ALU_ADD;
            3'b001: alu_op = ALU_SLL;
            3'b010: alu_op = ALU_SLT;
            3'b011: alu_op = ALU_SLTU;
            3'b100: alu_op = ALU_XOR;
            3'b101: alu_op = instr30 ? ALU_SRA : ALU_SRL;
            3'b110: alu_op = ALU_OR;
            3'b111: alu_op = ALU_AND;
         endcase
      end
   end

endmodule

// File: rtl/mc_control_fsm.sv
// ----------------------------------------------------------------------------
// mc_control_fsm
// Multi-cycle control unit for the workshop RV32I core. Steps through
// FETCH / DECODE / EXEC / MEM / WB, sharing one ALU and one single-port
// memory with a req/ready handshake.
//   clk  in  core clock
//   rst  in  asynchronous, active-high reset
//   bus  mc_control_fsm_if.master - instr/mem_ready/br_taken in, all datapath
//        controls, state_o and illegal out
// Only the state and the sticky illegal flag are registered; every control
// output is decoded combinationally from state and instr and forced low while
// rst is high.
// Build option: define ILLEGAL_TRAP_EN to park in TRAP on an illegal
// instruction (illegal=1 until reset); otherwise illegal instructions retire
// as NOPs and illegal stays 0.
// ----------------------------------------------------------------------------
module mc_control_fsm
   import riscv_ctrl_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   mc_control_fsm_if.master      bus
);

   state_e     state;
   alu_op_e    dec_op;
   logic [6:0] opcode;
   logic       instr_legal;
   logic       is_op, is_op_imm, is_lui, is_auipc, is_load, is_store;
   logic       is_branch, is_jal, is_jalr, is_fence;
   logic       cls_a_sel, cls_b_sel;

   assign opcode      = bus.instr[6:0];
   assign instr_legal = opcode_legal(opcode);
   assign is_op       = (opcode == OPC_OP);
   assign is_op_imm   = (opcode == OPC_OP_IMM);
   assign is_lui      = (opcode == OPC_LUI);
   assign is_auipc    = (opcode == OPC_AUIPC);
   assign is_load     = (opcode == OPC_LOAD);
   assign is_store    = (opcode == OPC_STORE);
   assign is_branch   = (opcode == OPC_BRANCH);
   assign is_jal      = (opcode == OPC_JAL);
   assign is_jalr     = (opcode == OPC_JALR);
   assign is_fence    = (opcode == OPC_FENCE);

   alu_op_decoder u_alu_op_decoder (
      .opcode  (opcode),
      .funct3  (bus.instr[14:12]),
      .instr30 (bus.instr[30]),
      .alu_op  (dec_op)
   );

   // Operand selects per instruction class. PC is the A operand for
   // PC-relative targets (AUIPC, branches, JAL); only register-register ops
   // take rs2 as the B operand.
   always_comb begin
      cls_a_sel = is_auipc | is_branch | is_jal;
      cls_b_sel = ~is_op;
   end

`ifdef ILLEGAL_TRAP_EN
   logic illegal_q;
`endif

   // Control sequencer. Memory states only advance on mem_ready; all other
   // states take exactly one cycle. Decoding that finishes the instruction
   // early (FENCE, control transfers, stores) returns straight to FETCH.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= RESET_STATE;
`ifdef ILLEGAL_TRAP_EN
         illegal_q <= 1'b0;
`endif
      end else begin
         case (state)
            FETCH: begin
               if (bus.mem_ready) state <= DECODE;
            end
            DECODE: begin
               if (!instr_legal) begin
`ifdef ILLEGAL_TRAP_EN
                  state     <= TRAP;
                  illegal_q <= 1'b1;
`else
                  state <= FETCH;
`endif
               end else if (is_fence) begin
                  state <= FETCH;
               end else begin
                  state <= EXEC;
               end
            end
            EXEC: begin
               if (is_op || is_op_imm || is_lui || is_auipc)
                  state <= WB;
               else if (is_load || is_store)
                  state <= MEM;
               else
                  state <= FETCH;
            end
            MEM: begin
               if (bus.mem_ready) state <= is_store ? FETCH : WB;
            end
            WB: begin
               state <= FETCH;
            end
`ifdef ILLEGAL_TRAP_EN
            TRAP: begin
               state <= TRAP;
            end
`endif
            default: begin
               state <= RESET_STATE;
            end
         endcase
      end
   end

   // Datapath controls. The ALU op and operand selects stay valid from EXEC
   // through MEM and WB so the address / result stays stable while memory
   // stalls or the register file writes. A store only bumps the PC in the
   // cycle memory accepts it, so a stall cannot advance the PC repeatedly.
   always_comb begin
      bus.mem_req      = 1'b0;
      bus.mem_we       = 1'b0;
      bus.mem_addr_sel = 1'b0;
      bus.ir_we        = 1'b0;
      bus.pc_we        = 1'b0;
      bus.pc_sel       = PC_SEL_PC4;
      bus.alu_op       = ALU_ADD;
      bus.alu_a_sel    = 1'b0;
      bus.alu_b_sel    = 1'b0;
      bus.reg_we       = 1'b0;
      bus.wb_sel       = WB_SEL_ALU;
      if (!rst) begin
         case (state)
            FETCH: begin
               bus.mem_req = 1'b1;
               bus.ir_we   = bus.mem_ready;
            end
            DECODE: begin
`ifndef ILLEGAL_TRAP_EN
               if (!instr_legal) bus.pc_we = 1'b1;
`endif
               if (instr_legal && is_fence) bus.pc_we = 1'b1;
            end
            EXEC: begin
               bus.alu_op    = dec_op;
               bus.alu_a_sel = cls_a_sel;
               bus.alu_b_sel = cls_b_sel;
               if (is_branch) begin
                  bus.pc_we  = 1'b1;
                  bus.pc_sel = bus.br_taken ? PC_SEL_ALU : PC_SEL_PC4;
               end
               if (is_jal || is_jalr) begin
                  bus.pc_we  = 1'b1;
                  bus.reg_we = 1'b1;
                  bus.wb_sel = WB_SEL_PC4;
                  bus.pc_sel = is_jal ? PC_SEL_ALU : PC_SEL_ALU_ALIGN;
               end
            end
            MEM: begin
               bus.alu_op       = dec_op;
               bus.alu_a_sel    = cls_a_sel;
               bus.alu_b_sel    = cls_b_sel;
               bus.mem_req      = 1'b1;
               bus.mem_addr_sel = 1'b1;
               bus.mem_we       = is_store;
               if (is_store && bus.mem_ready) bus.pc_we = 1'b1;
            end
            WB: begin
               bus.alu_op    = dec_op;
               bus.alu_a_sel = cls_a_sel;
               bus.alu_b_sel = cls_b_sel;
               bus.reg_we    = 1'b1;
               bus.wb_sel    = is_load ? WB_SEL_MEM : WB_SEL_ALU;
               bus.pc_we     = 1'b1;
            end
            default: begin
            end
         endcase
      end
   end

   // Debug state view and the sticky illegal flag, both forced low in reset.
   assign bus.state_o = rst ? 3'd0 : state;
`ifdef ILLEGAL_TRAP_EN
   assign bus.illegal = illegal_q & ~rst;
`else
   assign bus.illegal = 1'b0;
`endif

endmodule

// File: tb/tb_mc_control_fsm.sv
// ----------------------------------------------------------------------------
// tb_mc_control_fsm
// Directed, table-driven bench for mc_control_fsm. Each table row is one clock
// cycle: inputs are applied just after the rising edge and all outputs are
// compared at the falling edge against a hand-computed packed expectation.
// Extra hand-written sequences cover the illegal-instruction path (with and
// without ILLEGAL_TRAP_EN) and reset asserted during a stalled load.
// ----------------------------------------------------------------------------
module tb_mc_control_fsm;
   import riscv_ctrl_pkg::*;

   logic clk;
   logic rst;

   mc_control_fsm_if bus ();

   mc_control_fsm dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [31:0] instr;
      logic        rdy;
      logic        br;
      logic [19:0] exp;
   } vec_t;

   vec_t vecs[$];
   int   checks = 0;
   int   errors = 0;

   localparam logic [31:0] I_ADD   = 32'h002081B3;
   localparam logic [31:0] I_SUB   = 32'h402081B3;
   localparam logic [31:0] I_SRAI  = 32'h4030D093;
   localparam logic [31:0] I_SRLI  = 32'h0030D093;
   localparam logic [31:0] I_LW    = 32'h0080A283;
   localparam logic [31:0] I_SW    = 32'h0020A223;
   localparam logic [31:0] I_BEQ   = 32'h00208463;
   localparam logic [31:0] I_JAL   = 32'h008000EF;
   localparam logic [31:0] I_JALR  = 32'h000080E7;
   localparam logic [31:0] I_LUI   = 32'h123450B7;
   localparam logic [31:0] I_AUIPC = 32'h00000097;
   localparam logic [31:0] I_FENCE = 32'h0000000F;
   localparam logic [31:0] I_ZERO  = 32'h00000000;

   // Packed order: state, mem_req, mem_we, mem_addr_sel, ir_we, pc_we, pc_sel,
   // alu_op, alu_a_sel, alu_b_sel, reg_we, wb_sel, illegal.
   function automatic logic [19:0] packExp(
      input logic [2:0] st, input logic req, input logic we, input logic asel,
      input logic ir, input logic pcwe, input logic [1:0] pcsel,
      input logic [3:0] op, input logic a, input logic b, input logic rw,
      input logic [1:0] wb, input logic ill);
      return {st, req, we, asel, ir, pcwe, pcsel, op, a, b, rw, wb, ill};
   endfunction

   function automatic logic [19:0] actualOut();
      return {bus.state_o, bus.mem_req, bus.mem_we, bus.mem_addr_sel,
              bus.ir_we, bus.pc_we, bus.pc_sel, 4'(bus.alu_op), bus.alu_a_sel,
              bus.alu_b_sel, bus.reg_we, bus.wb_sel, bus.illegal};
   endfunction

   task automatic addVec(input string name, input logic [31:0] instr,
                         input logic rdy, input logic br, input logic [19:0] exp);
      vec_t v;
      v.name  = name;
      v.instr = instr;
      v.rdy   = rdy;
      v.br    = br;
      v.exp   = exp;
      vecs.push_back(v);
   endtask

   // Common FETCH (zero wait) and DECODE rows for a legal non-FENCE instruction.
   task automatic addFetchDecode(input string name, input logic [31:0] instr);
      addVec({name, ".fetch"},  instr, 1'b1, 1'b0,
             packExp(3'd0, 1,0,0,1,0, 2'd0, 4'd0, 0,0,0, 2'd0, 0));
      addVec({name, ".decode"}, instr, 1'b1, 1'b0,
             packExp(3'd1, 0,0,0,0,0, 2'd0, 4'd0, 0,0,0, 2'd0, 0));
   endtask

   // Four-cycle ALU-style instruction: FETCH, DECODE, EXEC, WB writing the ALU.
   task automatic addAluSeq(input string name, input logic [31:0] instr,
                            input logic [3:0] op, input logic a, input logic b);
      addFetchDecode(name, instr);
      addVec({name, ".exec"}, instr, 1'b1, 1'b0,
             packExp(3'd2, 0,0,0,0,0, 2'd0, op, a,b,0, 2'd0, 0));
      addVec({name, ".wb"},   instr, 1'b1, 1'b0,
             packExp(3'd4, 0,0,0,0,1, 2'd0, op, a,b,1, 2'd0, 0));
   endtask

   task automatic applyStimulus(input logic [31:0] instr, input logic rdy,
                                input logic br);
      bus.instr     = instr;
      bus.mem_ready = rdy;
      bus.br_taken  = br;
   endtask

   task automatic checkOutput(input string name, input logic [19:0] exp);
      logic [19:0] act;
      act = actualOut();
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s got=%05h expected=%05h", name, act, exp);
      end
   endtask

   // Sample at the falling edge, then move to just after the next rising edge.
   task automatic stepCheck(input string name, input logic [19:0] exp);
      @(negedge clk);
      checkOutput(name, exp);
      @(posedge clk);
      #1;
   endtask

   initial begin
      applyStimulus(I_ZERO, 1'b0, 1'b0);
      rst = 1'b0;
      #1 rst = 1'b1;

      // ---------------- table of per-cycle vectors ----------------
      addAluSeq("add",   I_ADD,   4'b0000, 0, 0);
      addAluSeq("sub",   I_SUB,   4'b0001, 0, 0);
      addAluSeq("srai",  I_SRAI,  4'b0100, 0, 1);
      addAluSeq("srli",  I_SRLI,  4'b0011, 0, 1);
      addAluSeq("lui",   I_LUI,   4'b1010, 0, 1);
      addAluSeq("auipc", I_AUIPC, 4'b0000, 1, 1);

      addVec("lw.fetch_wait", I_LW, 1'b0, 1'b0,
             packExp(3'd0, 1,0,0,0,0, 2'd0, 4'd0, 0,0,0, 2'd0, 0));
      addFetchDecode("lw", I_LW);
      addVec("lw.exec", I_LW, 1'b1, 1'b0,
             packExp(3'd2, 0,0,0,0,0, 2'd0, 4'd0, 0,1,0, 2'd0, 0));
      for (int i = 0; i < 3; i++)
         addVec($sformatf("lw.mem_wait%0d", i), I_LW, 1'b0, 1'b0,
                packExp(3'd3, 1,0,1,0,0, 2'd0, 4'd0, 0,1,0, 2'd0, 0));
      addVec("lw.mem_done", I_LW, 1'b1, 1'b0,
             packExp(3'd3, 1,0,1,0,0, 2'd0, 4'd0, 0,1,0, 2'd0, 0));
      addVec("lw.wb", I_LW, 1'b1, 1'b0,
             packExp(3'd4, 0,0,0,0,1, 2'd0, 4'd0, 0,1,1, 2'd1, 0));

      addFetchDecode("sw", I_SW);
      addVec("sw.exec", I_SW, 1'b1, 1'b0,
             packExp(3'd2, 0,0,0,0,0, 2'd0, 4'd0, 0,1,0, 2'd0, 0));
      addVec("sw.mem", I_SW, 1'b1, 1'b0,
             packExp(3'd3, 1,1,1,0,1, 2'd0, 4'd0, 0,1,0, 2'd0, 0));

      addFetchDecode("beq_t", I_BEQ);
      addVec("beq_t.exec", I_BEQ, 1'b1, 1'b1,
             packExp(3'd2, 0,0,0,0,1, 2'd1, 4'd0, 1,1,0, 2'd0, 0));
      addFetchDecode("beq_n", I_BEQ);
      addVec("beq_n.exec", I_BEQ, 1'b1, 1'b0,
             packExp(3'd2, 0,0,0,0,1, 2'd0, 4'd0, 1,1,0, 2'd0, 0));

      addFetchDecode("jal", I_JAL);
      addVec("jal.exec", I_JAL, 1'b1, 1'b0,
             packExp(3'd2, 0,0,0,0,1, 2'd1, 4'd0, 1,1,1, 2'd2, 0));
      addFetchDecode("jalr", I_JALR);
      addVec("jalr.exec", I_JALR, 1'b1, 1'b0,
             packExp(3'd2, 0,0,0,0,1, 2'd2, 4'd0, 0,1,1, 2'd2, 0));

      addVec("fence.fetch", I_FENCE, 1'b1, 1'b0,
             packExp(3'd0, 1,0,0,1,0, 2'd0, 4'd0, 0,0,0, 2'd0, 0));
      addVec("fence.decode", I_FENCE, 1'b1, 1'b0,
             packExp(3'd1, 0,0,0,0,1, 2'd0, 4'd0, 0,0,0, 2'd0, 0));

      // ---------------- reset state ----------------
      @(negedge clk);
      checkOutput("reset.idle", 20'h0);
      applyStimulus(I_ADD, 1'b1, 1'b1);
      @(negedge clk);
      checkOutput("reset.ready_ignored", 20'h0);
      @(posedge clk);
      #1 rst = 1'b0;

      // ---------------- table replay ----------------
      foreach (vecs[i]) begin
         applyStimulus(vecs[i].instr, vecs[i].rdy, vecs[i].br);
         stepCheck(vecs[i].name, vecs[i].exp);
      end

      // ---------------- illegal instruction ----------------
      applyStimulus(I_ZERO, 1'b1, 1'b0);
      stepCheck("ill.fetch", packExp(3'd0, 1,0,0,1,0, 2'd0, 4'd0, 0,0,0, 2'd0, 0));
`ifdef ILLEGAL_TRAP_EN
      stepCheck("ill.decode", packExp(3'd1, 0,0,0,0,0, 2'd0, 4'd0, 0,0,0, 2'd0, 0));
      for (int i = 0; i < 3; i++)
         stepCheck($sformatf("ill.trap%0d", i),
                   packExp(3'd5, 0,0,0,0,0, 2'd0, 4'd0, 0,0,0, 2'd0, 1));
      rst = 1'b1;
      #1;
      checkOutput("ill.trap_reset", 20'h0);
      @(posedge clk);
      #1 rst = 1'b0;
      stepCheck("ill.after_reset",
                packExp(3'd0, 1,0,0,1,0, 2'd0, 4'd0, 0,0,0, 2'd0, 0));
`else
      stepCheck("ill.decode", packExp(3'd1, 0,0,0,0,1, 2'd0, 4'd0, 0,0,0, 2'd0, 0));
      stepCheck("ill.next_fetch",
                packExp(3'd0, 1,0,0,1,0, 2'd0, 4'd0, 0,0,0, 2'd0, 0));
`endif

      // ---------------- reset during a stalled load ----------------
      applyStimulus(I_LW, 1'b1, 1'b0);
      // The row ahead of this one is a FETCH with mem_ready=1 in every build
      // (ill.next_fetch / ill.after_reset), so the load begins in DECODE.
      stepCheck("rst_mem.decode", packExp(3'd1, 0,0,0,0,0, 2'd0, 4'd0, 0,0,0, 2'd0, 0));
      stepCheck("rst_mem.exec",   packExp(3'd2, 0,0,0,0,0, 2'd0, 4'd0, 0,1,0, 2'd0, 0));
      applyStimulus(I_LW, 1'b0, 1'b0);
      @(negedge clk);
      checkOutput("rst_mem.mem_wait",
                  packExp(3'd3, 1,0,1,0,0, 2'd0, 4'd0, 0,1,0, 2'd0, 0));
      #2 rst = 1'b1;
      #1;
      checkOutput("rst_mem.in_reset", 20'h0);
      @(posedge clk);
      #1 rst = 1'b0;
      stepCheck("rst_mem.release",
                packExp(3'd0, 1,0,0,0,0, 2'd0, 4'd0, 0,0,0, 2'd0, 0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
